uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART 8N1 receiver: recovers bytes from the serial line rxd and presents them on a
//  valid/ready byte interface. Receive-side counterpart of the core's UART transmitter;
//  same WAIT_DIV bit timing (clock cycles per bit). Sits between the board RX pin and the
//  loader/IO FIFO. One-byte holding register; reports framing and overrun errors.
// PARAMETERS
//  WAIT_DIV  868  clock cycles per bit (e.g. 100 MHz / 115200); must be >= 4
//  (derived) WAIT_LEN = $clog2(WAIT_DIV), width of the bit-timing counter
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst_n      in   1  asynchronous active-low reset
//  rxd        in   1  serial input, asynchronous to clk, idle high
//  rdata      out  8  received byte, stable while rvalid=1
//  rvalid     out  1  rdata holds an unconsumed byte
//  rready     in   1  consumer accepts byte when rvalid&rready at posedge
//  frame_err  out  1  1-cycle pulse: stop bit sampled 0, byte discarded
//  overrun    out  1  1-cycle pulse: byte completed while holding register full, byte dropped
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, counters 0, rdata=8'h00, rvalid=0, frame_err=0,
//    overrun=0, synchronizer FFs=1. Reset mid-byte abandons the byte; no error pulses.
//  - rxd passes a 2-FF synchronizer -> rxd_s (2-cycle input latency); only rxd_s is used.
//  - States: IDLE, START, DATA, STOP, BREAK. wait_cnt counts 0..WAIT_DIV-1.
//  - IDLE: rxd_s==0 -> START, wait_cnt=0.
//  - START: at wait_cnt==WAIT_DIV/2-1 sample rxd_s: 0 -> DATA, wait_cnt=0, bit_cnt=0;
//    1 -> IDLE (glitch rejected, no pulse). Shorter-than-half-bit lows never yield a byte.
//  - DATA: at wait_cnt==WAIT_DIV-1 (mid-bit) shift sample in LSB first, wait_cnt=0;
//    after the 8th bit (bit_cnt==7) -> STOP.
//  - STOP: at wait_cnt==WAIT_DIV-1 sample stop bit:
//    1 -> if rvalid==0 or rready==1 this cycle: rdata<=shift, rvalid<=1 next cycle;
//         else overrun=1 for one cycle, rdata/rvalid unchanged. -> IDLE.
//    0 -> frame_err=1 for one cycle, byte discarded, -> BREAK.
//  - BREAK: wait for rxd_s==1 -> IDLE (held-low line / break never retriggers START).
//  - Handshake: rvalid clears the cycle after rvalid&rready unless a new byte loads
//    in the same cycle (load wins, rvalid stays 1). rdata never changes while rvalid=1
//    except on that simultaneous accept+load. rready ignored when rvalid=0.
//  - Latency: rvalid rises one cycle after the stop-bit mid-sample, i.e.
//    2 + WAIT_DIV/2 + 9*WAIT_DIV + 1 cycles after the rxd falling edge of the start bit.
//  - Next START is detectable the cycle after STOP->IDLE (back-to-back bytes supported;
//    the remaining half stop bit is high and ignored).
//  - Counters saturate nowhere; wait_cnt wraps to 0 only by explicit load above.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each START/DATA/STOP decision uses 2-of-3 majority of rxd_s
//    sampled at the decision count and the two preceding cycles (START: WAIT_DIV/2-3..-1,
//    others: WAIT_DIV-3..-1); single-cycle glitches at the sample point are rejected.
//  Not defined: single sample of rxd_s at the decision count only; no majority logic built.
//  Timing, state machine and all handshake rules identical in both builds.
// TESTING (bench WAIT_DIV=16)
//  1 send 0xA5 8N1, rready=0 -> rvalid=1, rdata=8'hA5 at start_edge+2+8+144+1 cycles,
//    held until rready pulse, then rvalid=0 next cycle; frame_err=overrun=0.
//  2 rxd low 5 cycles then high -> back to IDLE, rvalid stays 0, no error pulses;
//    then send 0x3C -> rdata=8'h3C.
//  3 send 0x55 with stop bit 0, hold rxd low 40 cycles -> one frame_err pulse, no rvalid,
//    no further pulses while low; release and send 0x81 -> rdata=8'h81.
//  4 send 0x11 then 0x22 back-to-back, rready=0 -> rdata=8'h11 valid, overrun pulse at
//    2nd stop sample, rdata still 8'h11; with rready=1 throughout both bytes delivered.
//  5 rst_n low for 3 cycles in DATA of 0x7E -> all outputs 0 immediately; next 0xC3
//    received correctly.
//  6 UART_RX_MAJORITY_EN: 1-cycle high glitch at mid of bit 0 of 0x00 -> rdata=8'h00;
//    without macro the same stimulus -> rdata=8'h01.

Source files
------------

// File: rtl/uart_rx.sv
// UART 8N1 receiver with a one-byte holding register, valid/ready output, and
// framing/overrun pulses. Optional UART_RX_MAJORITY_EN enables 2-of-3 majority sampling.
module uart_rx #(
   parameter int WAIT_DIV = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rdata,
   output logic       rvalid,
   input  logic       rready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int WAIT_LEN = $clog2(WAIT_DIV);
   localparam logic [WAIT_LEN-1:0] HALF_LAST = WAIT_LEN'(WAIT_DIV / 2 - 1);
   localparam logic [WAIT_LEN-1:0] FULL_LAST = WAIT_LEN'(WAIT_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t              r_state;
   logic [WAIT_LEN-1:0] r_waitCnt;
   logic [2:0]          r_bitCnt;
   logic [7:0]          r_shift;
   logic [7:0]          r_rdata;
   logic                r_rvalid;
   logic                r_frameErr;
   logic                r_overrun;
   logic                r_sync1;
   logic                r_rxdS;

   state_t              w_stateNext;
   logic [WAIT_LEN-1:0] w_waitNext;
   logic [2:0]          w_bitNext;
   logic [7:0]          w_shiftNext;
   logic [7:0]          w_rdataNext;
   logic                w_rvalidNext;
   logic                w_frameErrNext;
   logic                w_overrunNext;
   logic                w_sample;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_rxdS  <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_rxdS  <= r_sync1;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // The two previous synchronized samples; vote is taken at the decision count.
   logic [1:0] r_hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hist <= 2'b11;
      end else begin
         r_hist <= {r_hist[0], r_rxdS};
      end
   end

   assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rxdS) | (r_hist[0] & r_rxdS);
`else
   assign w_sample = r_rxdS;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_waitCnt  <= '0;
         r_bitCnt   <= '0;
         r_shift    <= '0;
         r_rdata    <= '0;
         r_rvalid   <= 1'b0;
         r_frameErr <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_waitCnt  <= w_waitNext;
         r_bitCnt   <= w_bitNext;
         r_shift    <= w_shiftNext;
         r_rdata    <= w_rdataNext;
         r_rvalid   <= w_rvalidNext;
         r_frameErr <= w_frameErrNext;
         r_overrun  <= w_overrunNext;
      end
   end

   always_comb begin
      w_stateNext    = r_state;
      w_waitNext     = r_waitCnt + 1'b1;
      w_bitNext      = r_bitCnt;
      w_shiftNext    = r_shift;
      w_rdataNext    = r_rdata;
      w_rvalidNext   = r_rvalid & ~rready;
      w_frameErrNext = 1'b0;
      w_overrunNext  = 1'b0;

      case (r_state)
         IDLE: begin
            w_waitNext = '0;
            if (!r_rxdS) begin
               w_stateNext = START;
            end
         end
         START: begin
            if (r_waitCnt == HALF_LAST) begin
               w_waitNext = '0;
               if (!w_sample) begin
                  w_stateNext = DATA;
                  w_bitNext   = '0;
               end else begin
                  w_stateNext = IDLE;
               end
            end
         end
         DATA: begin
            if (r_waitCnt == FULL_LAST) begin
               w_waitNext  = '0;
               w_shiftNext = {w_sample, r_shift[7:1]};
               w_bitNext   = r_bitCnt + 3'd1;
               if (r_bitCnt == 3'd7) begin
                  w_stateNext = STOP;
               end
            end
         end
         STOP: begin
            if (r_waitCnt == FULL_LAST) begin
               w_waitNext = '0;
               if (w_sample) begin
                  w_stateNext = IDLE;
                  // A load in the same cycle as an accept keeps rvalid asserted.
                  if (!r_rvalid || rready) begin
                     w_rdataNext  = r_shift;
                     w_rvalidNext = 1'b1;
                  end else begin
                     w_overrunNext = 1'b1;
                  end
               end else begin
                  w_stateNext    = BREAK;
                  w_frameErrNext = 1'b1;
               end
            end
         end
         BREAK: begin
            w_waitNext = '0;
            if (r_rxdS) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_waitNext  = '0;
         end
      endcase
   end

   assign rdata     = r_rdata;
   assign rvalid    = r_rvalid;
   assign frame_err = r_frameErr;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with WAIT_DIV=16; the glitch test's
// expected byte depends on whether UART_RX_MAJORITY_EN is defined.
module tb_uart_rx;

   localparam int WAIT_DIV = 16;

   logic       clk;
   logic       rst_n;
   logic       rxd;
   logic [7:0] rdata;
   logic       rvalid;
   logic       rready;
   logic       frame_err;
   logic       overrun;

   int         checks;
   int         errors;
   int         feCount;
   int         ovCount;
   bit         captureEn;
   logic [7:0] captured[$];

   uart_rx #(.WAIT_DIV(WAIT_DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rxd       (rxd),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .rready    (rready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Error pulses are counted and delivered bytes captured away from the active edge.
   always @(negedge clk) begin
      if (frame_err === 1'b1) feCount++;
      if (overrun === 1'b1) ovCount++;
      if (captureEn && rvalid === 1'b1 && rready) captured.push_back(rdata);
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic sendPartial(input logic [7:0] data, input logic stopBit, input int nbits);
      logic [9:0] frame;
      frame = {stopBit, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         rxd = frame[i];
         repeat (WAIT_DIV) @(negedge clk);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      sendPartial(data, stopBit, 10);
   endtask

   task automatic acceptByte(input string tag, input logic [7:0] expected);
      checkOutput({tag, " rvalid"}, 32'(rvalid), 32'd1);
      checkOutput({tag, " rdata"}, 32'(rdata), 32'(expected));
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      checkOutput({tag, " rvalid cleared"}, 32'(rvalid), 32'd0);
   endtask

   // Byte 0x00 with a single high cycle at the middle of bit 0.
   task automatic sendGlitchZero();
      rxd = 1'b0;
      repeat (24) @(negedge clk);
      rxd = 1'b1;
      @(negedge clk);
      rxd = 1'b0;
      repeat (7 + 7 * WAIT_DIV) @(negedge clk);
      rxd = 1'b1;
      repeat (WAIT_DIV) @(negedge clk);
   endtask

   initial begin
      int fe0;
      int ov0;
      logic [7:0] glitchExp;

      checks    = 0;
      errors    = 0;
      feCount   = 0;
      ovCount   = 0;
      captureEn = 1'b0;
      rst_n     = 1'b0;
      rxd       = 1'b1;
      rready    = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("reset rvalid", 32'(rvalid), 32'd0);
      checkOutput("reset rdata", 32'(rdata), 32'd0);
      checkOutput("reset frame_err", 32'(frame_err), 32'd0);
      checkOutput("reset overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Test 1: latency, hold while not accepted, clear after accept.
      fork
         applyStimulus(8'hA5, 1'b1);
         begin
            repeat (154) @(negedge clk);
            checkOutput("t1 rvalid before latency", 32'(rvalid), 32'd0);
            @(negedge clk);
            checkOutput("t1 rvalid at latency", 32'(rvalid), 32'd1);
            checkOutput("t1 rdata at latency", 32'(rdata), 32'hA5);
         end
      join
      repeat (20) @(negedge clk);
      acceptByte("t1 held", 8'hA5);
      checkOutput("t1 no frame_err", 32'(feCount), 32'd0);
      checkOutput("t1 no overrun", 32'(ovCount), 32'd0);

      // Test 2: short low glitch is rejected.
      rxd = 1'b0;
      repeat (5) @(negedge clk);
      rxd = 1'b1;
      repeat (30) @(negedge clk);
      checkOutput("t2 glitch no rvalid", 32'(rvalid), 32'd0);
      checkOutput("t2 glitch no frame_err", 32'(feCount), 32'd0);
      applyStimulus(8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      acceptByte("t2 byte", 8'h3C);

      // Test 3: framing error followed by a held-low line.
      fe0 = feCount;
      applyStimulus(8'h55, 1'b0);
      rxd = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("t3 one frame_err", 32'(feCount - fe0), 32'd1);
      checkOutput("t3 no rvalid", 32'(rvalid), 32'd0);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("t3 frame_err after release", 32'(feCount - fe0), 32'd1);
      applyStimulus(8'h81, 1'b1);
      repeat (4) @(negedge clk);
      acceptByte("t3 byte", 8'h81);

      // Test 4: overrun with rready low, then back-to-back delivery with rready high.
      ov0 = ovCount;
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("t4 one overrun", 32'(ovCount - ov0), 32'd1);
      acceptByte("t4 first kept", 8'h11);
      rready    = 1'b1;
      captureEn = 1'b1;
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      repeat (4) @(negedge clk);
      captureEn = 1'b0;
      rready    = 1'b0;
      checkOutput("t4 delivered count", 32'(captured.size()), 32'd2);
      checkOutput("t4 delivered 0", (captured.size() > 0) ? 32'(captured[0]) : 32'hDEAD, 32'h11);
      checkOutput("t4 delivered 1", (captured.size() > 1) ? 32'(captured[1]) : 32'hDEAD, 32'h22);
      checkOutput("t4 no new overrun", 32'(ovCount - ov0), 32'd1);

      // Test 5: asynchronous reset in the middle of a byte.
      applyStimulus(8'h5A, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("t5 pending before reset", 32'(rvalid), 32'd1);
      fe0 = feCount;
      ov0 = ovCount;
      fork
         sendPartial(8'h7E, 1'b1, 4);
         begin
            repeat (60) @(negedge clk);
            #1 rst_n = 1'b0;
            #1;
            checkOutput("t5 reset rvalid", 32'(rvalid), 32'd0);
            checkOutput("t5 reset rdata", 32'(rdata), 32'd0);
            checkOutput("t5 reset frame_err", 32'(frame_err), 32'd0);
            checkOutput("t5 reset overrun", 32'(overrun), 32'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("t5 abandoned no rvalid", 32'(rvalid), 32'd0);
      checkOutput("t5 no error pulses", 32'((feCount - fe0) + (ovCount - ov0)), 32'd0);
      applyStimulus(8'hC3, 1'b1);
      repeat (4) @(negedge clk);
      acceptByte("t5 byte", 8'hC3);

      // Test 6: sample-point glitch; majority voting filters it out.
`ifdef UART_RX_MAJORITY_EN
      glitchExp = 8'h00;
`else
      glitchExp = 8'h01;
`endif
      sendGlitchZero();
      repeat (4) @(negedge clk);
      acceptByte("t6 glitch byte", glitchExp);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
